// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide, XLEN+1 cycles to done
// (divide-by-zero and signed overflow finish after one cycle); starts are ignored while busy.
module rv32m_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int ENABLE_DIV = 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [31:0]     insn,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            claim,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op, op_q;
  logic            is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] special_res;
  logic            neg_q, rneg_q;
  logic [XLEN-1:0] mcand, acc_hi, acc_lo;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [XLEN:0]   mul_add, mul_sum, div_shl, div_sub;
  logic            div_ge;
  logic [XLEN-1:0] hi_nxt, lo_nxt, quo, rem;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] final_res;
  logic            unused_insn;

  assign unused_insn = ^{insn[24:15], insn[11:7]};

  assign op    = insn[14:12];
  assign claim = (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) &&
                 ((ENABLE_DIV != 0) || !insn[14]);

  assign is_div     = op[2] && (ENABLE_DIV != 0);
  assign rs1_signed = is_div ? !op[0] : (op != 3'b011);
  assign rs2_signed = is_div ? !op[0] : !op[1];
  assign rs1_neg    = rs1_signed && rs1_data[XLEN-1];
  assign rs2_neg    = rs2_signed && rs2_data[XLEN-1];
  assign rs1_mag    = rs1_neg ? -rs1_data : rs1_data;
  assign rs2_mag    = rs2_neg ? -rs2_data : rs2_data;

  // Degenerate divides bypass the iteration and complete straight from the issue cycle.
  assign div_zero    = is_div && (rs2_data == '0);
  assign div_ovf     = is_div && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (rs2_data == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : rs1_data);

  assign accept = start && claim && !flush && ((state == IDLE) || (state == DONE));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);
  assign last   = (cnt == CW'(XLEN - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) state_nxt = special ? DONE : CALC;
          else        state_nxt = IDLE;
        end
        CALC:    if (last) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mul_add = acc_lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}};
  assign mul_sum = {1'b0, acc_hi} + mul_add;
  assign div_shl = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge  = (div_shl >= {1'b0, mcand});
  assign div_sub = div_shl - {1'b0, mcand};

  always_comb begin
    hi_nxt = mul_sum[XLEN:1];
    lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
    if (op_q[2]) begin
      hi_nxt = div_ge ? div_sub[XLEN-1:0] : div_shl[XLEN-1:0];
      lo_nxt = {acc_lo[XLEN-2:0], div_ge};
    end
  end

  // Signs are applied only to the completed magnitudes on the final step.
  assign prod   = {hi_nxt, lo_nxt};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo_nxt : lo_nxt;
  assign rem    = rneg_q ? -hi_nxt : hi_nxt;

  always_comb begin
    final_res = prod_s[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         final_res = prod_s[XLEN-1:0];
      3'b100, 3'b101: final_res = quo;
      3'b110, 3'b111: final_res = rem;
      default:        final_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q   <= op;
      neg_q  <= rs1_neg ^ rs2_neg;
      rneg_q <= rs1_neg;
      mcand  <= is_div ? rs2_mag : rs1_mag;
      acc_hi <= '0;
      acc_lo <= is_div ? rs1_mag : rs2_mag;
      cnt    <= '0;
      if (special) result <= special_res;
    end else if ((state == CALC) && !flush) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= cnt + CW'(1);
      if (last) result <= final_res;
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboarded random/directed bench for rv32m_muldiv_unit (XLEN=32) plus a multiply-only instance.
module tb_rv32m_muldiv_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] insn, rs1_data, rs2_data, result;
  logic        start, flush, claim, busy, done;
  logic [31:0] insn2, rs1b, rs2b, result2;
  logic        start2, flush2, claim2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] last_res;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  rv32m_muldiv_unit #(.XLEN(32), .ENABLE_DIV(1)) u_dut (
    .CLK(CLK), .nRST(nRST), .insn(insn), .start(start), .flush(flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .claim(claim), .busy(busy), .done(done), .result(result)
  );

  rv32m_muldiv_unit #(.XLEN(32), .ENABLE_DIV(0)) u_dut_nd (
    .CLK(CLK), .nRST(nRST), .insn(insn2), .start(start2), .flush(flush2),
    .rs1_data(rs1b), .rs2_data(rs2b),
    .claim(claim2), .busy(busy2), .done(done2), .result(result2)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
  endfunction

  // Reference results straight from the ISA arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub, p;
    logic [63:0]        up;
    logic [31:0]        r;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sub = {32'b0, b};
    up  = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: begin p = sa * sb;  r = p[31:0];  end
      3'd1: begin p = sa * sb;  r = p[63:32]; end
      3'd2: begin p = sa * sub; r = p[63:32]; end
      3'd3: r = up[63:32];
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if (f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (nRST && done) begin
      check("busy_at_done", {63'b0, busy}, 64'd0);
      if (sbq.size() == 0) begin
        check("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        e = sbq.pop_front();
        check("result", {32'b0, result}, {32'b0, e.res});
        check("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int lat, input bit push);
    int w = 0;
    while (busy && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (busy) begin
      check("issue_wait", {63'b0, busy}, 64'd0);
      return;
    end
    insn = mk(f3); rs1_data = a; rs2_data = b; start = 1'b1;
    if (push) begin
      sbq.push_back('{er, cyc + lat});
      last_res = er;
    end
    @(negedge CLK);
    start = 1'b0;
    if (lat > 1) check("busy_calc", {63'b0, busy}, 64'd1);
  endtask

  task automatic issue_rand(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    issue(f3, a, b, model(f3, a, b), lat_of(f3, a, b), 1'b1);
  endtask

  task automatic drain();
    int w = 0;
    while ((sbq.size() != 0 || busy || done) && w < 100) begin
      @(negedge CLK);
      w++;
    end
    check("drain_queue", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t1, w;
    nRST = 1'b0; start = 1'b0; flush = 1'b0; insn = '0; rs1_data = '0; rs2_data = '0;
    start2 = 1'b0; flush2 = 1'b0; insn2 = '0; rs1b = '0; rs2b = '0;
    last_res = '0;
    #12;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_result", {32'b0, result}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Directed vectors, many issued back-to-back in the DONE cycle.
    issue(3'd0, 32'hFFFF_FFFF, 32'd7,          32'hFFFF_FFF9, 33, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 33, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 1'b1);
    issue(3'd4, -32'sd7,       32'd2,          32'hFFFF_FFFD, 33, 1'b1);
    issue(3'd6, -32'sd7,       32'd2,          32'hFFFF_FFFF, 33, 1'b1);
    issue(3'd5, 32'd1234,      32'd0,          32'hFFFF_FFFF, 1,  1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1,  1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 1,  1'b1);
    issue(3'd7, 32'd5,         32'd0,          32'd5,         1,  1'b1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 33, 1'b1);
    drain();

    // A start during CALC must not disturb the running operation.
    issue(3'd0, 32'd1000, 32'd1000, 32'd1_000_000, 33, 1'b1);
    repeat (4) @(negedge CLK);
    insn = mk(3'd5); rs1_data = 32'd9; rs2_data = 32'd0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    drain();

    // Unclaimed encodings are ignored.
    for (int f = 0; f < 8; f++) begin
      insn = mk(3'(f));
      #1 check("claim_m", {63'b0, claim}, 64'd1);
    end
    insn = mk(3'd0); insn[6:0] = 7'b0110111;
    #1 check("claim_opcode", {63'b0, claim}, 64'd0);
    insn = mk(3'd0); insn[31:25] = 7'b0000000;
    #1 check("claim_funct7", {63'b0, claim}, 64'd0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("unclaimed_busy", {63'b0, busy}, 64'd0);

    // flush wins over start in IDLE.
    insn = mk(3'd0); rs1_data = 32'd3; rs2_data = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'b0, busy}, 64'd0);

    // Flush mid-multiply: back to IDLE, no done, result held.
    issue(3'd0, 32'd77, 32'd88, 32'd0, 33, 1'b0);
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_done", {63'b0, done}, 64'd0);
    check("flush_result", {32'b0, result}, {32'b0, last_res});
    repeat (40) @(negedge CLK);
    check("flush_result_held", {32'b0, result}, {32'b0, last_res});

    // Randomized traffic with occasional idle gaps.
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      issue_rand(3'($urandom_range(0, 7)), rnd_op(), rnd_op());
    end
    drain();

    // Reset during CALC abandons the operation.
    issue(3'd5, 32'd1000, 32'd7, 32'd0, 33, 1'b0);
    repeat (5) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_result", {32'b0, result}, 64'd0);
    last_res = '0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    check("postrst_result", {32'b0, result}, 64'd0);
    issue_rand(3'd7, 32'd100, 32'd7);
    drain();

    // Multiply-only build.
    for (int f = 0; f < 8; f++) begin
      insn2 = mk(3'(f));
      #1 check("nd_claim", {63'b0, claim2}, (f < 4) ? 64'd1 : 64'd0);
    end
    @(negedge CLK);
    insn2 = mk(3'd5); rs1b = 32'd10; rs2b = 32'd3; start2 = 1'b1;
    @(negedge CLK);
    start2 = 1'b0;
    check("nd_div_busy", {63'b0, busy2}, 64'd0);
    check("nd_div_done", {63'b0, done2}, 64'd0);
    insn2 = mk(3'd0); rs1b = -32'sd7; rs2b = 32'd3; start2 = 1'b1;
    t1 = cyc;
    @(negedge CLK);
    start2 = 1'b0;
    w = 0;
    while (!done2 && w < 60) begin @(negedge CLK); w++; end
    check("nd_done1_cycle", 64'(cyc), 64'(t1 + 33));
    check("nd_result1", {32'b0, result2}, 64'h0000_0000_FFFF_FFEB);
    insn2 = mk(3'd0); rs1b = 32'd5; rs2b = 32'd6; start2 = 1'b1;
    t1 = cyc;
    @(negedge CLK);
    start2 = 1'b0;
    w = 0;
    while (!done2 && w < 60) begin @(negedge CLK); w++; end
    check("nd_done2_cycle", 64'(cyc), 64'(t1 + 33));
    check("nd_result2", {32'b0, result2}, 64'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
RV32M_MULDIV_UNIT -- requirements
Module: rv32m_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 Parameter ENABLE_DIV, default 1; 0 = multiply-only build, and divide/remainder encodings are not claimed.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 nRST  input  1  reset, asynchronous and active-low.
REQ-005 insn  input  32  candidate instruction word.
REQ-006 start  input  1  issue request; qualified by claim.
REQ-007 flush  input  1  abort any in-flight operation.
REQ-008 rs1_data  input  XLEN  operand A (dividend/multiplicand).
REQ-009 rs2_data  input  XLEN  operand B (divisor/multiplier).
REQ-010 claim  output  1  combinational: insn is a supported M-extension encoding.
REQ-011 busy  output  1  operation in progress; new starts ignored.
REQ-012 done  output  1  one-cycle pulse; result valid.
REQ-013 result  output  XLEN  operation result, held until next accepted start.

Function
REQ-014 claim SHALL be 1 iff insn[6:0]=0110011, insn[31:25]=0000001, and (ENABLE_DIV=1 or insn[14]=0).
REQ-015 Operation SHALL be selected by insn[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-016 States SHALL be IDLE, CALC, DONE.
REQ-017 Start is accepted in cycle T iff start=1, claim=1, flush=0, and state is IDLE or DONE; operands and operation are latched at T.
REQ-018 start with claim=0, or while in CALC, SHALL be ignored with no state change.
REQ-019 Normal accepted start: CALC for cycles T+1..T+XLEN (busy=1), DONE at T+XLEN+1 (done=1, busy=0), then IDLE unless a new start is accepted in DONE.
REQ-020 Multiply SHALL iterate one radix-2 shift-add step per CALC cycle on operand magnitudes, forming a 2*XLEN product, with the sign applied in the final step.
REQ-021 MUL returns the low XLEN bits; MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned, each returning the high XLEN bits.
REQ-022 Divide SHALL perform one restoring step per CALC cycle on magnitudes; signed quotient truncates toward zero, and the remainder takes the dividend's sign.
REQ-023 Divisor zero: skip CALC, DONE at T+1; DIV/DIVU result all ones, REM/REMU result rs1.
REQ-024 Signed overflow (DIV/REM, rs1=-2^(XLEN-1), rs2=-1): skip CALC, DONE at T+1; DIV result rs1, REM result 0.
REQ-025 flush=1 in any cycle SHALL force IDLE next cycle with no done pulse; result retains its prior value; flush has priority over start.
REQ-026 result SHALL update only in the cycle done rises.
REQ-027 Iteration counter SHALL be clog2(XLEN)+1 bits and must not wrap before XLEN steps complete.

Reset
REQ-028 nRST=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, and clear all operand and counter registers.
REQ-029 Reset asserted mid-CALC SHALL abandon the operation; no done follows reset release.
REQ-030 The first start may be accepted on the first rising edge after nRST deasserts.

Verification (XLEN=32)
REQ-031 MUL, rs1=0xFFFFFFFF (-1), rs2=7, start at T -> busy T+1..T+32, done at T+33, result 0xFFFFFFF9.
REQ-032 MULHU, rs1=rs2=0xFFFFFFFF -> result 0xFFFFFFFE at T+33; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-033 DIV, rs1=-7, rs2=2 -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); both at T+33.
REQ-034 DIVU, rs2=0 -> done at T+1, result 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> done at T+1, result 0x80000000.
REQ-035 flush at T+10 of a MUL -> IDLE at T+11, no done, result unchanged; start asserted during CALC -> ignored.
REQ-036 ENABLE_DIV=0: DIVU encoding -> claim=0, start ignored; back-to-back MUL starts issued in the DONE cycle -> second done 33 cycles after the first.
